return_change_dispenser: RTL and testbench
==========================================

Name: return_change_dispenser

Overview:
- Downstream stage of the coin-return timer logic in the vending machine.
- Once the return timer expires, or the user presses return, it latches the current balance and pays it out greedily, one coin per clock, largest denomination first.
- It reports busy/done status and any unreturnable residue back to the balance/state logic.

Parameters:
- COIN0_VAL, 100, value of coin index 0 (smallest)
- COIN1_VAL, 500, value of coin index 1
- COIN2_VAL, 1000, value of coin index 2 (largest)
- BAL_W, 31, balance width in bits (matches kTotalBits)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_start_return  in  1  request to return change (timer expiry or user request); level or pulse, sampled only in IDLE
- i_balance  in  BAL_W  current credited balance, sampled on the accepted start edge
- o_return_coin  out  kNumCoins  one-hot coin ejected this cycle; all-zero when no coin
- o_busy  out  1  high while state != IDLE
- o_done  out  1  one-cycle pulse when payout completes
- o_residue  out  BAL_W  balance left unpaid (< COIN0_VAL); valid while o_done is high, held until the next o_done

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rem=0, o_return_coin=0, o_done=0, o_residue=0, o_busy=0. Reset mid-payout aborts immediately; no further coins are issued.
- States: IDLE, DISPENSE, DONE. o_busy is decoded from state only, with no extra register.
- IDLE:
  - Edge with i_start_return=1: rem<=i_balance.
  - Next state is DISPENSE if i_balance>=COIN0_VAL, else DONE.
  - Otherwise stay in IDLE.
- DISPENSE, each edge:
  - Pick c = largest coin with value<=rem.
  - o_return_coin<=onehot(c); rem<=rem-val(c).
  - If rem-val(c)<COIN0_VAL, next state is DONE; else stay.
  - Exactly one coin per cycle.
- DONE, one edge: o_return_coin<=0, o_done<=1, o_residue<=rem, rem<=0, state<=IDLE.
- o_done is forced to 0 on every edge where it is not being set.
- Latency:
  - Start sampled at edge N: first coin visible after edge N+1.
  - k coins: last coin after edge N+k, o_done after edge N+k+1.
  - Zero-coin case: o_done after edge N+1.
- o_return_coin is registered and is 0 in every cycle except coin cycles.
- i_start_return and i_balance changes while busy are ignored; no queuing.
- Start asserted in the same cycle the block returns to IDLE is honoured on the following edge, giving back-to-back operation.
- Arithmetic:
  - Unsigned compares and subtraction on BAL_W bits; rem never underflows.
  - Balances that are not multiples of COIN0_VAL leave residue = balance mod COIN0_VAL.

Decomposition:
- vending_machine_def.v supplies kNumCoins, kTotalBits and the coin value constants.
- Add state encodings kRetIdle/kRetDispense/kRetDone to that file.
- One natural combinational sub-module, coin_greedy_select: inputs rem; outputs onehot coin and coin value. It is reusable by the balance logic.

Test Plan:
- Reset mid-payout: balance 3000, assert reset_n=0 after the 2nd coin -> outputs clear asynchronously; no 3rd coin; state IDLE.
- Start with balance 1600 -> coins 100(1000), 010(500), 001(100) on 3 consecutive cycles; o_done pulse next cycle; o_residue=0; o_busy high for 4 cycles.
- Start with balance 0 -> no coins; o_done one cycle after start; residue 0. Repeat with balance 50 -> residue 50.
- Balance 2700 -> sequence 1000, 1000, 500, 100, 100 (5 cycles), then done.
- Start held high continuously with balance 500 -> single coin 010, done, then immediate restart; balance change to 1000 mid-payout is ignored until the next start.

Source files
------------

// File: rtl/return_change_dispenser_pkg.sv
// Shared vending-machine constants for the change-return path: coin set,
// balance width and the return FSM state encodings.
package return_change_dispenser_pkg;

    localparam int unsigned kNumCoins  = 3;
    localparam int unsigned kTotalBits = 31;

    // Coin index 0 is the smallest denomination, index kNumCoins-1 the largest.
    localparam int unsigned kCoin0Val = 100;
    localparam int unsigned kCoin1Val = 500;
    localparam int unsigned kCoin2Val = 1000;

    localparam logic [1:0] kRetIdle     = 2'd0;
    localparam logic [1:0] kRetDispense = 2'd1;
    localparam logic [1:0] kRetDone     = 2'd2;

    typedef logic [kNumCoins-1:0] coin_onehot_t;

    function automatic coin_onehot_t coin_onehot(input logic [1:0] idx);
        coin_onehot_t oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/return_change_dispenser_coin_greedy_select.sv
// Combinational greedy picker: largest coin whose value fits in rem_i.
// Returns an all-zero one-hot and zero value when no coin fits.
module return_change_dispenser_coin_greedy_select
    import return_change_dispenser_pkg::*;
#(
    parameter int unsigned     BAL_W     = kTotalBits,
    parameter logic [BAL_W-1:0] COIN0_VAL = BAL_W'(kCoin0Val),
    parameter logic [BAL_W-1:0] COIN1_VAL = BAL_W'(kCoin1Val),
    parameter logic [BAL_W-1:0] COIN2_VAL = BAL_W'(kCoin2Val)
) (
    input  logic [BAL_W-1:0]     rem_i,
    output logic [kNumCoins-1:0] coin_o,
    output logic [BAL_W-1:0]     coin_val_o
);

    always_comb begin
        coin_o     = '0;
        coin_val_o = '0;
        if (rem_i >= COIN2_VAL) begin
            coin_o     = coin_onehot(2'd2);
            coin_val_o = COIN2_VAL;
        end else if (rem_i >= COIN1_VAL) begin
            coin_o     = coin_onehot(2'd1);
            coin_val_o = COIN1_VAL;
        end else if (rem_i >= COIN0_VAL) begin
            coin_o     = coin_onehot(2'd0);
            coin_val_o = COIN0_VAL;
        end
    end

endmodule

// File: rtl/return_change_dispenser.sv
// Pays out a latched balance greedily, one coin per clock, largest first,
// and reports completion plus the unpayable residue.
module return_change_dispenser
    import return_change_dispenser_pkg::*;
#(
    parameter int unsigned     BAL_W     = kTotalBits,
    parameter logic [BAL_W-1:0] COIN0_VAL = BAL_W'(kCoin0Val),
    parameter logic [BAL_W-1:0] COIN1_VAL = BAL_W'(kCoin1Val),
    parameter logic [BAL_W-1:0] COIN2_VAL = BAL_W'(kCoin2Val)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start_return,
    input  logic [BAL_W-1:0]     i_balance,
    output logic [kNumCoins-1:0] o_return_coin,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [BAL_W-1:0]     o_residue
);

    // Start protocol: i_start_return is a request with no ready; it is
    // accepted on any edge where the FSM is in IDLE, and i_balance is captured
    // on that same edge. While busy, both inputs are ignored (nothing queues),
    // so a held request restarts the payout as soon as IDLE is re-entered.

    logic [1:0]           state_q, state_d;
    logic [BAL_W-1:0]     rem_q, rem_d;
    logic [kNumCoins-1:0] coin_q, coin_d;
    logic                 done_q, done_d;
    logic [BAL_W-1:0]     residue_q, residue_d;

    logic [kNumCoins-1:0] sel_coin;
    logic [BAL_W-1:0]     sel_val;
    logic [BAL_W-1:0]     rem_after;

    return_change_dispenser_coin_greedy_select #(
        .BAL_W     (BAL_W),
        .COIN0_VAL (COIN0_VAL),
        .COIN1_VAL (COIN1_VAL),
        .COIN2_VAL (COIN2_VAL)
    ) u_select (
        .rem_i      (rem_q),
        .coin_o     (sel_coin),
        .coin_val_o (sel_val)
    );

    // sel_val never exceeds rem_q, so this cannot underflow.
    assign rem_after = rem_q - sel_val;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        coin_d    = '0;
        done_d    = 1'b0;
        residue_d = residue_q;
        case (state_q)
            kRetIdle: begin
                if (i_start_return) begin
                    rem_d   = i_balance;
                    state_d = (i_balance >= COIN0_VAL) ? kRetDispense : kRetDone;
                end
            end
            kRetDispense: begin
                coin_d = sel_coin;
                rem_d  = rem_after;
                if (rem_after < COIN0_VAL) begin
                    state_d = kRetDone;
                end
            end
            kRetDone: begin
                done_d    = 1'b1;
                residue_d = rem_q;
                rem_d     = '0;
                state_d   = kRetIdle;
            end
            default: begin
                rem_d   = '0;
                state_d = kRetIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= kRetIdle;
            rem_q     <= '0;
            coin_q    <= '0;
            done_q    <= 1'b0;
            residue_q <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            coin_q    <= coin_d;
            done_q    <= done_d;
            residue_q <= residue_d;
        end
    end

    assign o_return_coin = coin_q;
    assign o_done        = done_q;
    assign o_residue     = residue_q;
    assign o_busy        = (state_q != kRetIdle);

endmodule

// File: tb/tb_return_change_dispenser.sv
// Scoreboard bench for return_change_dispenser: expected coin/done events are
// queued when a payout is started and popped as the DUT emits them.
module tb_return_change_dispenser;

    localparam int BAL_W = 31;
    localparam int EW    = 1 + 3 + BAL_W;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             i_start_return = 1'b0;
    logic [BAL_W-1:0] i_balance = '0;
    logic [2:0]       o_return_coin;
    logic             o_busy;
    logic             o_done;
    logic [BAL_W-1:0] o_residue;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_got;

    return_change_dispenser dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_start_return (i_start_return),
        .i_balance      (i_balance),
        .o_return_coin  (o_return_coin),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_residue      (o_residue)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack_ev(input logic d, input logic [2:0] c, input logic [BAL_W-1:0] r);
        return {d, c, r};
    endfunction

    // Reference greedy payout: queue each coin, then the done event with residue.
    function automatic int push_payout(input logic [BAL_W-1:0] bal);
        logic [BAL_W-1:0] rem;
        int k;
        rem = bal;
        k = 0;
        while (rem >= 100) begin
            if (rem >= 1000) begin
                exp_q.push_back(pack_ev(1'b0, 3'b100, '0));
                rem = rem - 1000;
            end else if (rem >= 500) begin
                exp_q.push_back(pack_ev(1'b0, 3'b010, '0));
                rem = rem - 500;
            end else begin
                exp_q.push_back(pack_ev(1'b0, 3'b001, '0));
                rem = rem - 100;
            end
            k++;
        end
        exp_q.push_back(pack_ev(1'b1, 3'b000, rem));
        return k;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (o_return_coin !== 3'b000 || o_done !== 1'b0) begin
            mon_got = pack_ev(o_done, o_return_coin, o_done ? o_residue : '0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_output", 64'(mon_got), 64'd0);
            end else begin
                check_val(o_done ? "done_event" : "coin_event", 64'(mon_got), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_payout(input logic [BAL_W-1:0] bal);
        int k;
        int j;
        int busy_cnt;
        k = push_payout(bal);
        @(negedge clk);
        i_balance      = bal;
        i_start_return = 1'b1;
        @(posedge clk);
        #1;
        i_start_return = 1'b0;
        i_balance      = BAL_W'($urandom_range(0, 9000));
        j = 0;
        busy_cnt = 0;
        while (j < 64) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
            if (o_done) break;
            j++;
        end
        check_val("done_latency", 64'(j), 64'(k + 1));
        check_val("busy_cycles", 64'(busy_cnt), 64'(k + 1));
        @(negedge clk);
        check_val("done_single_pulse", 64'(o_done), 64'd0);
        check_val("residue_held", 64'(o_residue), 64'(bal % 100));
    endtask

    task automatic run_held_start;
        int j;
        int first_done;
        int second_done;
        void'(push_payout(BAL_W'(500)));
        void'(push_payout(BAL_W'(1000)));
        @(negedge clk);
        i_balance      = BAL_W'(500);
        i_start_return = 1'b1;
        @(posedge clk);
        #1;
        i_balance = BAL_W'(1000);
        first_done  = -1;
        second_done = -1;
        j = 0;
        while (j < 20 && second_done < 0) begin
            @(negedge clk);
            if (o_done) begin
                if (first_done < 0) first_done = j;
                else second_done = j;
            end
            if (j == 4) i_start_return = 1'b0;
            j++;
        end
        check_val("held_first_done", 64'(first_done), 64'd2);
        check_val("held_second_done", 64'(second_done), 64'd5);
        repeat (3) @(negedge clk);
        check_val("held_idle_after", 64'(o_busy), 64'd0);
    endtask

    task automatic run_reset_mid_payout;
        int j;
        exp_q.push_back(pack_ev(1'b0, 3'b100, '0));
        exp_q.push_back(pack_ev(1'b0, 3'b100, '0));
        @(negedge clk);
        i_balance      = BAL_W'(3000);
        i_start_return = 1'b1;
        @(posedge clk);
        #1;
        i_start_return = 1'b0;
        for (j = 0; j < 3; j++) @(negedge clk);
        check_val("rst_second_coin_seen", 64'(o_return_coin), 64'(3'b100));
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_async_coin", 64'(o_return_coin), 64'd0);
        check_val("rst_async_busy", 64'(o_busy), 64'd0);
        check_val("rst_async_done", 64'(o_done), 64'd0);
        check_val("rst_async_residue", 64'(o_residue), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_val("rst_no_more_coins", 64'({o_return_coin, o_busy}), 64'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_coin", 64'(o_return_coin), 64'd0);
        check_val("reset_busy", 64'(o_busy), 64'd0);
        check_val("reset_done", 64'(o_done), 64'd0);
        check_val("reset_residue", 64'(o_residue), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_payout(BAL_W'(1600));
        run_payout(BAL_W'(0));
        run_payout(BAL_W'(50));
        run_payout(BAL_W'(2700));
        run_payout(BAL_W'(1234));
        run_held_start();
        run_payout(BAL_W'(99));
        run_reset_mid_payout();
        for (int r = 0; r < 6; r++) begin
            run_payout(BAL_W'($urandom_range(0, 5000)));
        end
        run_payout(BAL_W'(100));

        repeat (3) @(negedge clk);
        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
